// File: rtl/axi4_multi_channel_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_multi_channel_buffer_pkg
//  Description : Default parameter values and the count-width helper shared
//                by the multi-channel buffer and its per-channel queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_multi_channel_buffer_pkg;

  localparam int DEF_N_CH  = 5;
  localparam int DEF_WIDTH = 48;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_PIPE  = 1;
  localparam int DEF_FLOW  = 0;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : axi4_multi_channel_buffer_pkg
`default_nettype wire

// File: rtl/axi4_multi_channel_buffer_queue.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_queue
//  Description : Single-channel valid/ready queue of DEPTH entries with
//                optional pass-through-when-full (PIPE) and zero-latency
//                flow-through when empty (FLOW).
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_queue
  import axi4_multi_channel_buffer_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int PIPE  = DEF_PIPE,
  parameter  int FLOW  = DEF_FLOW,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [CW-1:0]    count_o
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam bit            PIPE_EN  = (PIPE != 0);
  localparam bit            FLOW_EN  = (FLOW != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  logic full, empty, enq, deq, bypass, store, fetch;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);

  // A full queue can still accept when PIPE lets the same-cycle dequeue
  // make room; nothing is accepted while reset is held.
  assign s_ready_o = !reset && (!full || (PIPE_EN && m_ready_i));
  assign m_valid_o = !empty || (FLOW_EN && s_valid_i);
  assign m_data_o  = (FLOW_EN && empty) ? s_data_i : mem_q[rd_ptr_q];

  assign enq    = s_valid_i && s_ready_o;
  assign deq    = m_valid_o && m_ready_i;
  // Empty flow-through beat consumed in the same cycle never touches storage.
  assign bypass = FLOW_EN && empty && enq && deq;
  assign store  = enq && !bypass;
  assign fetch  = deq && !empty;
  assign count_o = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (fetch) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (deq && !enq) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clock) begin
    if (store) mem_q[wr_ptr_q] <= s_data_i;
  end

endmodule : buffer_queue
`default_nettype wire

// File: rtl/axi4_multi_channel_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_multi_channel_buffer
//  Description : N_CH independent valid/ready channel queues placed between
//                the core AXI4 master port and the fabric, with per-channel
//                occupancy and an aggregate idle flag for clock gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_multi_channel_buffer
  import axi4_multi_channel_buffer_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int PIPE  = DEF_PIPE,
  parameter  int FLOW  = DEF_FLOW,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       s_valid,
  output logic [N_CH-1:0]       s_ready,
  input  logic [N_CH*WIDTH-1:0] s_data,
  output logic [N_CH-1:0]       m_valid,
  input  logic [N_CH-1:0]       m_ready,
  output logic [N_CH*WIDTH-1:0] m_data,
  output logic [N_CH*CW-1:0]    count,
  output logic                  idle
);

  logic [N_CH-1:0] ch_empty;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    buffer_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PIPE  (PIPE),
      .FLOW  (FLOW)
    ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .s_valid_i (s_valid[i]),
      .s_ready_o (s_ready[i]),
      .s_data_i  (s_data[i*WIDTH +: WIDTH]),
      .m_valid_o (m_valid[i]),
      .m_ready_i (m_ready[i]),
      .m_data_o  (m_data[i*WIDTH +: WIDTH]),
      .count_o   (count[i*CW +: CW])
    );

    assign ch_empty[i] = (count[i*CW +: CW] == '0);
  end

  // Idle only when nothing is stored and nothing is being offered.
  assign idle = (&ch_empty) && !(|s_valid);

endmodule : axi4_multi_channel_buffer
`default_nettype wire

// File: tb/tb_axi4_multi_channel_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_multi_channel_buffer
//  Description : Directed and randomized self-checking bench for the
//                multi-channel buffer (default build plus a FLOW=1 build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_multi_channel_buffer;

  localparam int N  = 5;
  localparam int W  = 48;
  localparam int CW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     s_valid, s_ready, m_valid, m_ready;
  logic [N*W-1:0]   s_data, m_data;
  logic [N*CW-1:0]  count;
  logic             idle;

  logic [N-1:0]     f_s_valid, f_s_ready, f_m_valid, f_m_ready;
  logic [N*W-1:0]   f_s_data, f_m_data;
  logic [N*CW-1:0]  f_count;
  logic             f_idle;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  axi4_multi_channel_buffer dut (
    .clock   (clock),   .reset   (reset),
    .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
    .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
    .count   (count),   .idle    (idle)
  );

  axi4_multi_channel_buffer #(.FLOW(1)) dut_flow (
    .clock   (clock),     .reset   (reset),
    .s_valid (f_s_valid), .s_ready (f_s_ready), .s_data (f_s_data),
    .m_valid (f_m_valid), .m_ready (f_m_ready), .m_data (f_m_data),
    .count   (f_count),   .idle    (f_idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt(input int i);
    return 64'(count[i*CW +: CW]);
  endfunction

  function automatic logic [63:0] dat(input int i);
    return 64'(m_data[i*W +: W]);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [W-1:0] d);
    s_valid[i]       = v;
    s_data[i*W +: W] = d;
  endtask

  logic [W-1:0] q [N][$];
  int           seq [N];
  logic         pend [N];
  logic         stall [N];
  logic [W-1:0] held [N];
  logic         exp_idle;

  initial begin
    reset = 1'b1;
    s_valid = '0; s_data = '0; m_ready = '0;
    f_s_valid = '0; f_s_data = '0; f_m_ready = '0;

    // ---- Reset and idle ----
    repeat (3) step();
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_count",   64'(count),   64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'h1f);
    chk("post_rst_m_valid", 64'(m_valid), 64'h0);
    chk("post_rst_idle",    64'(idle),    64'h1);
    step();

    // ---- Fill to full, then drain with a third beat waiting ----
    set_ch(0, 1'b1, 48'hA);
    #1 chk("t2_ready_a", 64'(s_ready[0]), 64'h1);
    step();
    chk("t2_cnt1",   cnt(0), 64'h1);
    chk("t2_head_a", dat(0), 64'hA);
    set_ch(0, 1'b1, 48'hB);
    step();
    chk("t2_cnt2",    cnt(0), 64'h2);
    chk("t2_full_rdy", 64'(s_ready[0]), 64'h0);
    chk("t2_not_idle", 64'(idle), 64'h0);
    set_ch(0, 1'b1, 48'hC);
    step();
    chk("t2_c_blocked", cnt(0), 64'h2);
    chk("t2_stable_a",  dat(0), 64'hA);
    m_ready[0] = 1'b1;
    #1 chk("t2_pipe_rdy", 64'(s_ready[0]), 64'h1);
    step();
    chk("t2_pop_b", dat(0), 64'hB);
    chk("t2_cnt_b", cnt(0), 64'h2);
    s_valid[0] = 1'b0;
    step();
    chk("t2_pop_c", dat(0), 64'hC);
    chk("t2_cnt_c", cnt(0), 64'h1);
    step();
    chk("t2_empty_cnt", cnt(0), 64'h0);
    chk("t2_empty_mv",  64'(m_valid[0]), 64'h0);
    m_ready[0] = 1'b0;

    // ---- Full queue streaming with PIPE ----
    set_ch(0, 1'b1, 48'h10); step();
    set_ch(0, 1'b1, 48'h11); step();
    chk("t3_full", cnt(0), 64'h2);
    m_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 1'b1, 48'(32'h12 + k));
      #1;
      chk("t3_head",  dat(0), 64'(32'h10 + k));
      chk("t3_ready", 64'(s_ready[0]), 64'h1);
      step();
      chk("t3_cnt", cnt(0), 64'h2);
    end
    s_valid[0] = 1'b0;
    #1 chk("t3_tail0", dat(0), 64'h14);
    step();
    chk("t3_tail1", dat(0), 64'h15);
    step();
    chk("t3_drained", cnt(0), 64'h0);
    m_ready[0] = 1'b0;

    // ---- Zero-latency flow-through on the FLOW=1 build ----
    f_s_valid[2] = 1'b1;
    f_s_data[2*W +: W] = 48'h1234;
    f_m_ready[2] = 1'b1;
    #1;
    chk("t4_mv",   64'(f_m_valid[2]), 64'h1);
    chk("t4_data", 64'(f_m_data[2*W +: W]), 64'h1234);
    chk("t4_cnt0", 64'(f_count[2*CW +: CW]), 64'h0);
    step();
    chk("t4_cnt_after", 64'(f_count[2*CW +: CW]), 64'h0);
    f_s_valid[2] = 1'b0;
    f_m_ready[2] = 1'b0;
    #1;
    chk("t4_mv_off", 64'(f_m_valid[2]), 64'h0);
    chk("t4_idle",   64'(f_idle), 64'h1);

    // ---- Reset discards stored entries ----
    set_ch(1, 1'b1, 48'h21); step();
    set_ch(1, 1'b1, 48'h22); step();
    s_valid[1] = 1'b0;
    chk("t5_cnt2", cnt(1), 64'h2);
    reset = 1'b1;
    #1 chk("t5_rst_rdy", 64'(s_ready), 64'h0);
    step();
    reset = 1'b0;
    #1;
    chk("t5_mv",  64'(m_valid[1]), 64'h0);
    chk("t5_cnt", cnt(1), 64'h0);
    chk("t5_rdy", 64'(s_ready[1]), 64'h1);
    set_ch(1, 1'b1, 48'h55);
    step();
    s_valid[1] = 1'b0;
    #1;
    chk("t5_new_mv",  64'(m_valid[1]), 64'h1);
    chk("t5_new_dat", dat(1), 64'h55);
    m_ready[1] = 1'b1;
    step();
    chk("t5_drain", cnt(1), 64'h0);
    m_ready = '0;

    // ---- Random traffic against a per-channel scoreboard ----
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; pend[i] = 1'b0; stall[i] = 1'b0; held[i] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          s_valid[i]       = 1'($urandom_range(0, 1));
          s_data[i*W +: W] = {8'(i), 40'(seq[i])};
        end
        m_ready[i] = 1'($urandom_range(0, 1));
      end
      #1;
      exp_idle = (s_valid == '0);
      for (int i = 0; i < N; i++) if (q[i].size() != 0) exp_idle = 1'b0;
      chk("sb_idle", 64'(idle), 64'(exp_idle));
      for (int i = 0; i < N; i++) begin
        chk("sb_count",   cnt(i), 64'(q[i].size()));
        chk("sb_m_valid", 64'(m_valid[i]), 64'(q[i].size() != 0));
        chk("sb_s_ready", 64'(s_ready[i]), 64'(q[i].size() < 2 || m_ready[i]));
        if (stall[i]) chk("sb_stable", dat(i), 64'(held[i]));
        if (m_valid[i] && m_ready[i]) begin
          if (q[i].size() == 0) chk("sb_underflow", 64'h1, 64'h0);
          else chk("sb_order", dat(i), 64'(q[i].pop_front()));
        end
        if (s_valid[i] && s_ready[i]) begin
          q[i].push_back(s_data[i*W +: W]);
          seq[i]++;
          pend[i] = 1'b0;
        end else begin
          pend[i] = s_valid[i];
        end
        stall[i] = m_valid[i] && !m_ready[i];
        held[i]  = m_data[i*W +: W];
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_axi4_multi_channel_buffer
`default_nettype wire
